// File: rtl/reference_reader_if.sv
// Read port toward reference_buffer plus the outgoing I/Q sample stream.
// master = reference_reader side, slave = buffer/consumer side.
interface reference_reader_if #(
   parameter int I_BITS     = 12,
   parameter int Q_BITS     = 12,
   parameter int INDEX_BITS = 7
);
   logic [INDEX_BITS-1:0]    m_axi_raddr;
   logic                     m_axi_rvalid;
   logic                     m_axi_rready;
   logic                     s_axi_rready;
   logic                     s_axi_rvalid;
   logic signed [I_BITS-1:0] i;
   logic signed [Q_BITS-1:0] q;
   logic signed [I_BITS-1:0] out_i;
   logic signed [Q_BITS-1:0] out_q;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;

   modport master (
      output m_axi_raddr, m_axi_rvalid, m_axi_rready, out_i, out_q, out_valid, out_last,
      input  s_axi_rready, s_axi_rvalid, i, q, out_ready
   );

   modport slave (
      input  m_axi_raddr, m_axi_rvalid, m_axi_rready, out_i, out_q, out_valid, out_last,
      output s_axi_rready, s_axi_rvalid, i, q, out_ready
   );
endinterface

// File: rtl/reference_reader.sv
// Walks reference_buffer circularly from a programmable index and streams the
// returned I/Q samples through a small FIFO, issuing reads against FIFO credit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; stray returns only raise err
// S_ISSUE | issuing reads while outstanding + stored < FIFO_DEPTH
// S_DRAIN | all reads issued; waiting for the last sample to leave
module reference_reader #(
   parameter int I_BITS        = 12,
   parameter int Q_BITS        = 12,
   parameter int BUFFER_LENGTH = 100,
   parameter int INDEX_BITS    = 7,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [INDEX_BITS-1:0] start_index,
   reference_reader_if.master    bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int CW  = $clog2(BUFFER_LENGTH + 1);
   localparam int OW  = $clog2(FIFO_DEPTH + 1);
   localparam int OW1 = OW + 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]         LAST_CNT  = CW'(BUFFER_LENGTH - 1);
   localparam logic [INDEX_BITS-1:0] LAST_ADDR = INDEX_BITS'(BUFFER_LENGTH - 1);
   localparam logic [OW:0]           DEPTH_C   = OW1'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                   state, state_nxt;
   logic [INDEX_BITS-1:0]    addr;
   logic [CW-1:0]            issue_cnt, ret_cnt;
   logic [OW-1:0]            outstanding, fifo_count;
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic signed [I_BITS-1:0] mem_i [FIFO_DEPTH];
   logic signed [Q_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]    mem_last;
   logic                     quiet;
   logic                     req_valid, credit_ok, accept, ret, pop, fifo_valid;

   assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
   assign accept     = req_valid && bus.s_axi_rready;
   assign ret        = bus.s_axi_rvalid && (outstanding != '0);
   assign fifo_valid = (fifo_count != '0);
   assign pop        = fifo_valid && bus.out_ready;

   assign busy             = (state != S_IDLE);
   assign bus.m_axi_raddr  = addr;
   assign bus.m_axi_rvalid = req_valid;
   assign bus.m_axi_rready = busy;
   assign bus.out_valid    = fifo_valid;
   assign bus.out_i        = mem_i[rd_ptr];
   assign bus.out_q        = mem_q[rd_ptr];
   assign bus.out_last     = fifo_valid && mem_last[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_valid = 1'b0;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: begin
            req_valid = credit_ok;
            if (credit_ok && bus.s_axi_rready && issue_cnt == LAST_CNT) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (pop && bus.out_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // quiet masks err after a reset so returns from an aborted pass are dropped silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr        <= '0;
         issue_cnt   <= '0;
         ret_cnt     <= '0;
         outstanding <= '0;
         err         <= 1'b0;
         quiet       <= 1'b1;
         done        <= 1'b0;
      end else begin
         done <= (state == S_DRAIN) && pop && bus.out_last;
         if (state == S_IDLE && start) begin
            addr      <= start_index;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            quiet     <= 1'b0;
         end else begin
            if (accept) begin
               addr      <= (addr == LAST_ADDR) ? '0 : addr + INDEX_BITS'(1);
               issue_cnt <= issue_cnt + CW'(1);
            end
            if (ret) ret_cnt <= ret_cnt + CW'(1);
         end
         case ({accept, ret})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
         if (bus.s_axi_rvalid && outstanding == '0 && !quiet) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         mem_last   <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_i[k] <= '0;
            mem_q[k] <= '0;
         end
      end else begin
         if (ret) begin
            mem_i[wr_ptr]    <= bus.i;
            mem_q[wr_ptr]    <= bus.q;
            mem_last[wr_ptr] <= (ret_cnt == LAST_CNT);
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({ret, pop})
            2'b10:   fifo_count <= fifo_count + OW'(1);
            2'b01:   fifo_count <= fifo_count - OW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end
endmodule
